// File: rtl/pc_fetch_redirect_pkg.sv
// Shared fetch-stage widths, PC-select codes and fetch FSM encodings.
package pc_fetch_redirect_pkg;

  localparam int unsigned WIDTH_PC       = 32;
  localparam int unsigned WIDTH_PCSEL    = 1;
  localparam int unsigned WIDTH_FETCH_ST = 2;

  localparam logic [WIDTH_PCSEL-1:0] PCSEL_PC4  = 1'b0;
  localparam logic [WIDTH_PCSEL-1:0] PCSEL_JUMP = 1'b1;

  // Legacy-visible state encodings; the enum below reuses them verbatim.
  localparam logic [WIDTH_FETCH_ST-1:0] FETCH_ST_RUN  = 2'b00;
  localparam logic [WIDTH_FETCH_ST-1:0] FETCH_ST_PEND = 2'b01;
  localparam logic [WIDTH_FETCH_ST-1:0] FETCH_ST_HALT = 2'b10;

  typedef enum logic [WIDTH_FETCH_ST-1:0] {
    ST_RUN  = FETCH_ST_RUN,
    ST_PEND = FETCH_ST_PEND,
    ST_HALT = FETCH_ST_HALT
  } fetch_st_e;

  // A fetch target is usable only on a 4-byte boundary.
  function automatic logic is_aligned(input logic [WIDTH_PC-1:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/pc_fetch_redirect_sat_counter.sv
// Saturating up-counter with enable and asynchronous active-high reset.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count
);

  // Count enabled cycles, sticking at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pc_fetch_redirect.sv
// IF-stage PC owner: sequential fetch, jump/branch redirects (also while
// instruction memory is busy), IF/ID flush and misaligned-target trap.
module pc_fetch_redirect
  import pc_fetch_redirect_pkg::*;
#(
  parameter logic [WIDTH_PC-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned         CNT_W    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH_PCSEL-1:0] PCSel,
  input  logic [WIDTH_PC-1:0]    jump_target,
  input  logic                   id_valid,
  input  logic                   imem_ready,
  output logic                   imem_req,
  output logic [WIDTH_PC-1:0]    imem_addr,
  output logic [WIDTH_PC-1:0]    pc_IF,
  output logic                   flush_IFID,
  output logic                   misalign_exc,
  output logic [WIDTH_PC-1:0]    misalign_addr,
  output logic [CNT_W-1:0]       redirect_cnt
);

  fetch_st_e           state;
  logic [WIDTH_PC-1:0] pend_pc;
  logic                redir;
  logic                bad;
  logic                accept;

  // Decode the ID-stage redirect request and classify it.
  always_comb begin
    redir  = id_valid && (PCSel == PCSEL_JUMP);
    bad    = redir && !is_aligned(jump_target);
    accept = redir && !bad && (state != ST_HALT);
  end

  // Request/flush outputs; both are forced low while reset is held.
  always_comb begin
    imem_addr  = pc_IF;
    imem_req   = !rst && (state != ST_HALT);
    flush_IFID = !rst && ((state != ST_RUN) || redir);
  end

  // Fetch FSM: RUN and PEND share the redirect rules; PEND completes the
  // parked target on the first imem_ready unless a newer redirect arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_RUN;
      pc_IF         <= RESET_PC;
      pend_pc       <= '0;
      misalign_exc  <= 1'b0;
      misalign_addr <= '0;
    end else begin
      misalign_exc <= 1'b0;
      case (state)
        ST_RUN, ST_PEND: begin
          if (bad) begin
            state         <= ST_HALT;
            misalign_exc  <= 1'b1;
            misalign_addr <= jump_target;
          end else if (redir) begin
            if (imem_ready) begin
              pc_IF <= jump_target;
              state <= ST_RUN;
            end else begin
              pend_pc <= jump_target;
              state   <= ST_PEND;
            end
          end else if (imem_ready) begin
            pc_IF <= (state == ST_PEND) ? pend_pc : pc_IF + WIDTH_PC'(4);
            state <= ST_RUN;
          end
        end
        default: begin
        end
      endcase
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_redirect_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (accept),
    .count(redirect_cnt)
  );

endmodule

// File: tb/tb_pc_fetch_redirect.sv
// Self-checking bench for pc_fetch_redirect: directed vectors with literal
// expectations plus a per-cycle behavioural reference model.
module tb_pc_fetch_redirect;
  import pc_fetch_redirect_pkg::*;

  localparam int CW   = 2;
  localparam int CMAX = 3;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [WIDTH_PCSEL-1:0] PCSel = PCSEL_PC4;
  logic [31:0]            jump_target = 32'h0;
  logic                   id_valid = 1'b0;
  logic                   imem_ready = 1'b1;
  logic                   imem_req;
  logic [31:0]            imem_addr;
  logic [31:0]            pc_IF;
  logic                   flush_IFID;
  logic                   misalign_exc;
  logic [31:0]            misalign_addr;
  logic [CW-1:0]          redirect_cnt;

  pc_fetch_redirect #(
    .RESET_PC(32'h0000_0000),
    .CNT_W   (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .PCSel        (PCSel),
    .jump_target  (jump_target),
    .id_valid     (id_valid),
    .imem_ready   (imem_ready),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .pc_IF        (pc_IF),
    .flush_IFID   (flush_IFID),
    .misalign_exc (misalign_exc),
    .misalign_addr(misalign_addr),
    .redirect_cnt (redirect_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: pc, an optional parked target, a halted flag, counters.
  logic [31:0] m_pc;
  logic [31:0] m_target;
  bit          m_pending;
  bit          m_halted;
  int          m_cnt;
  bit          m_exc;
  logic [31:0] m_maddr;

  always @(negedge clk) begin
    bit want_jump;
    if (rst) begin
      m_pc = 32'h0; m_target = 32'h0; m_pending = 0; m_halted = 0;
      m_cnt = 0; m_exc = 0; m_maddr = 32'h0;
    end
    want_jump = id_valid && (PCSel == PCSEL_JUMP);
    check("m_pc",    pc_IF, m_pc);
    check("m_addr",  imem_addr, m_pc);
    check("m_req",   32'(imem_req), 32'(!rst && !m_halted));
    check("m_flush", 32'(flush_IFID), 32'(!rst && (m_halted || m_pending || want_jump)));
    check("m_exc",   32'(misalign_exc), 32'(m_exc));
    check("m_maddr", misalign_addr, m_maddr);
    check("m_cnt",   32'(redirect_cnt), 32'(m_cnt));
    if (!rst) begin
      m_exc = 0;
      if (!m_halted) begin
        if (want_jump && (jump_target % 4 != 0)) begin
          m_halted = 1; m_exc = 1; m_maddr = jump_target; m_pending = 0;
        end else if (want_jump) begin
          m_cnt = (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
          if (imem_ready) begin
            m_pc = jump_target; m_pending = 0;
          end else begin
            m_target = jump_target; m_pending = 1;
          end
        end else if (imem_ready) begin
          m_pc = m_pending ? m_target : m_pc + 32'd4;
          m_pending = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [WIDTH_PCSEL-1:0] sel,
                       input logic [31:0] t, input bit r);
    id_valid = v; PCSel = sel; jump_target = t; imem_ready = r;
  endtask

  initial begin
    tick(); tick();
    check("rst_pc", pc_IF, 32'h0);
    check("rst_req", 32'(imem_req), 32'h0);
    check("rst_flush", 32'(flush_IFID), 32'h0);
    check("rst_cnt", 32'(redirect_cnt), 32'h0);
    check("rst_maddr", misalign_addr, 32'h0);
    rst = 1'b0;
    #1 check("run_req", 32'(imem_req), 32'h1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("seq_pc", pc_IF, 32'(4 * i));
      check("seq_flush", 32'(flush_IFID), 32'h0);
    end

    drive(1, PCSEL_JUMP, 32'h100, 1);
    #1 check("jmp_flush", 32'(flush_IFID), 32'h1);
    tick(); check("jmp_pc", pc_IF, 32'h100); check("jmp_cnt", 32'(redirect_cnt), 32'h1);
    drive(0, PCSEL_PC4, 32'h0, 1);
    #1 check("jmp_noflush", 32'(flush_IFID), 32'h0);
    tick(); check("jmp_pc4", pc_IF, 32'h104);

    drive(1, PCSEL_JUMP, 32'h200, 0);
    #1 check("pend_flush0", 32'(flush_IFID), 32'h1);
    tick(); check("pend_hold0", pc_IF, 32'h104);
    drive(0, PCSEL_PC4, 32'h0, 0);
    repeat (2) begin
      #1 check("pend_flush", 32'(flush_IFID), 32'h1);
      tick(); check("pend_hold", pc_IF, 32'h104);
    end
    drive(0, PCSEL_PC4, 32'h0, 1);
    #1 check("pend_flush3", 32'(flush_IFID), 32'h1);
    tick();
    check("pend_done", pc_IF, 32'h200);
    check("pend_run", 32'(flush_IFID), 32'h0);
    check("pend_cnt", 32'(redirect_cnt), 32'h2);
    tick(); check("pend_pc4", pc_IF, 32'h204);

    drive(1, PCSEL_JUMP, 32'h600, 0); tick();
    drive(1, PCSEL_JUMP, 32'h700, 0); tick();
    drive(0, PCSEL_PC4, 32'h0, 1); tick();
    check("newest_pc", pc_IF, 32'h700);
    check("newest_cnt", 32'(redirect_cnt), 32'h3);

    drive(1, PCSEL_JUMP, 32'hFFFF_FFF8, 1); tick();
    check("wrap_pre", pc_IF, 32'hFFFF_FFF8);
    drive(0, PCSEL_PC4, 32'h0, 1);
    tick(); check("wrap_fc", pc_IF, 32'hFFFF_FFFC);
    tick(); check("wrap_0", pc_IF, 32'h0);
    drive(0, PCSEL_JUMP, 32'h300, 1);
    #1 check("novalid_flush", 32'(flush_IFID), 32'h0);
    tick(); check("novalid_pc", pc_IF, 32'h4);

    drive(1, PCSEL_JUMP, 32'h102, 1);
    #1 check("bad_flush", 32'(flush_IFID), 32'h1);
    tick();
    check("bad_exc", 32'(misalign_exc), 32'h1);
    check("bad_maddr", misalign_addr, 32'h102);
    check("bad_pc", pc_IF, 32'h4);
    check("bad_req", 32'(imem_req), 32'h0);
    drive(0, PCSEL_PC4, 32'h0, 1); tick();
    check("halt_exc", 32'(misalign_exc), 32'h0);
    check("halt_pc", pc_IF, 32'h4);
    check("halt_flush", 32'(flush_IFID), 32'h1);
    drive(1, PCSEL_JUMP, 32'h400, 1); tick();
    check("halt_ign", pc_IF, 32'h4);
    check("halt_maddr", misalign_addr, 32'h102);
    drive(0, PCSEL_PC4, 32'h0, 1);
    rst = 1'b1;
    #1 check("hrst_pc", pc_IF, 32'h0);
    check("hrst_maddr", misalign_addr, 32'h0);
    check("hrst_cnt", 32'(redirect_cnt), 32'h0);
    tick(); rst = 1'b0;
    tick(); check("hrst_run", pc_IF, 32'h4);

    for (int i = 0; i < 5; i++) begin
      drive(1, PCSEL_JUMP, 32'(32'h40 * (i + 1)), 1);
      tick();
      check("sat_pc", pc_IF, 32'(32'h40 * (i + 1)));
      check("sat_cnt", 32'(redirect_cnt), 32'((i + 1 > CMAX) ? CMAX : i + 1));
    end

    drive(1, PCSEL_JUMP, 32'h500, 0); tick();
    drive(0, PCSEL_PC4, 32'h0, 0); tick();
    check("prst_hold", pc_IF, 32'h140);
    rst = 1'b1;
    #1 check("prst_pc", pc_IF, 32'h0);
    check("prst_flush", 32'(flush_IFID), 32'h0);
    check("prst_req", 32'(imem_req), 32'h0);
    tick(); rst = 1'b0;
    drive(0, PCSEL_PC4, 32'h0, 1);
    tick(); check("prst_pc4", pc_IF, 32'h4);
    tick(); check("prst_pc8", pc_IF, 32'h8);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
